// File: rtl/irq_ctrl.sv
// Interrupt controller: synchronises the external IRQ pins, detects edge or level events,
// latches pending state, masks it with enables, and exposes a claim register for the core.
module irq_ctrl #(
    parameter int NUM_IRQ     = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [1:0]         reg_sel,
    input  logic               reg_write,
    input  logic               reg_read,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               irq_out
);

    localparam int         ID_W        = $clog2(NUM_IRQ + 1);
    localparam logic [1:0] SEL_PENDING = 2'd0;
    localparam logic [1:0] SEL_ENABLE  = 2'd1;
    localparam logic [1:0] SEL_MODE    = 2'd2;
    localparam logic [1:0] SEL_CLAIM   = 2'd3;

    logic [NUM_IRQ-1:0] r_sync [SYNC_STAGES];
    logic [NUM_IRQ-1:0] r_prev;
    logic [NUM_IRQ-1:0] r_pending;
    logic [NUM_IRQ-1:0] r_enable;
    logic [NUM_IRQ-1:0] r_mode;
    logic               r_irq;

    logic [NUM_IRQ-1:0] w_s;
    logic [NUM_IRQ-1:0] w_rise;
    logic [NUM_IRQ-1:0] w_active;
    logic [NUM_IRQ-1:0] w_claim_mask;
    logic [ID_W-1:0]    w_claim_id;
    logic [NUM_IRQ-1:0] w_w1c;
    logic [NUM_IRQ-1:0] w_claim_clr;
    logic [NUM_IRQ-1:0] w_pending_next;
    logic               w_unused_wdata;

    assign w_s      = r_sync[SYNC_STAGES-1];
    assign w_rise   = w_s & ~r_prev;
    assign w_active = r_pending & r_enable;

    assign w_unused_wdata = ^wdata[31:NUM_IRQ];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
            r_prev <= '0;
        end else begin
            r_sync[0] <= irq_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev <= w_s;
        end
    end

    // Lowest-numbered active line wins the claim; scan high to low so the last hit is the lowest.
    always_comb begin
        w_claim_id   = '0;
        w_claim_mask = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_active[i]) begin
                w_claim_id      = ID_W'(i + 1);
                w_claim_mask    = '0;
                w_claim_mask[i] = 1'b1;
            end
        end
    end

    assign w_w1c       = (reg_write && (reg_sel == SEL_PENDING)) ? wdata[NUM_IRQ-1:0] : '0;
    assign w_claim_clr = (reg_read && (reg_sel == SEL_CLAIM)) ? w_claim_mask : '0;

    // Level lines simply track the synchronised pin; edge lines latch, with a new edge beating any clear.
    assign w_pending_next = (r_mode & w_s)
                          | (~r_mode & (w_rise | (r_pending & ~(w_w1c | w_claim_clr))));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pending <= '0;
            r_enable  <= '0;
            r_mode    <= '0;
            r_irq     <= 1'b0;
        end else begin
            r_pending <= w_pending_next;
            r_irq     <= |w_active;
            if (reg_write && (reg_sel == SEL_ENABLE)) begin
                r_enable <= wdata[NUM_IRQ-1:0];
            end
            if (reg_write && (reg_sel == SEL_MODE)) begin
                r_mode <= wdata[NUM_IRQ-1:0];
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (reg_sel)
            SEL_PENDING: rdata[NUM_IRQ-1:0] = r_pending;
            SEL_ENABLE:  rdata[NUM_IRQ-1:0] = r_enable;
            SEL_MODE:    rdata[NUM_IRQ-1:0] = r_mode;
            default:     rdata[ID_W-1:0]    = w_claim_id;
        endcase
    end

    assign irq_out = r_irq;

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: stimulus queues expected values, a negedge monitor compares them.
module tb_irq_ctrl;

    logic        clk;
    logic        rstn;
    logic [1:0]  irq_a;
    logic [7:0]  irq_b;
    logic [1:0]  reg_sel;
    logic        reg_write;
    logic        reg_read;
    logic [31:0] wdata;
    logic [31:0] rdata_a;
    logic [31:0] rdata_b;
    logic        irq_out_a;
    logic        irq_out_b;

    irq_ctrl #(.NUM_IRQ(2), .SYNC_STAGES(2)) u_dut_a (
        .clk       (clk),
        .rstn      (rstn),
        .irq_in    (irq_a),
        .reg_sel   (reg_sel),
        .reg_write (reg_write),
        .reg_read  (reg_read),
        .wdata     (wdata),
        .rdata     (rdata_a),
        .irq_out   (irq_out_a)
    );

    irq_ctrl #(.NUM_IRQ(8), .SYNC_STAGES(3)) u_dut_b (
        .clk       (clk),
        .rstn      (rstn),
        .irq_in    (irq_b),
        .reg_sel   (reg_sel),
        .reg_write (reg_write),
        .reg_read  (reg_read),
        .wdata     (wdata),
        .rdata     (rdata_b),
        .irq_out   (irq_out_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          dut_b;
        bit          is_irq;
        logic [31:0] exp;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    exp_t        mon_e;
    logic [31:0] mon_act;

    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            if (mon_e.dut_b) mon_act = mon_e.is_irq ? {31'b0, irq_out_b} : rdata_b;
            else             mon_act = mon_e.is_irq ? {31'b0, irq_out_a} : rdata_a;
            n_checks++;
            if (mon_act !== mon_e.exp) begin
                n_fail++;
                $display("FAIL %s: got 0x%0h, expected 0x%0h", mon_e.name, mon_act, mon_e.exp);
            end else begin
                $display("ok   %s: 0x%0h", mon_e.name, mon_act);
            end
        end
    end

    task automatic push(input string nm, input bit b, input bit is_irq, input logic [31:0] e);
        exp_t x;
        x.name   = nm;
        x.dut_b  = b;
        x.is_irq = is_irq;
        x.exp    = e;
        sb_q.push_back(x);
    endtask

    task automatic cyc(input logic [1:0] sel, input logic wr, input logic rd_s, input logic [31:0] wd);
        @(posedge clk);
        #1;
        reg_sel   = sel;
        reg_write = wr;
        reg_read  = rd_s;
        wdata     = wd;
    endtask

    task automatic idle();
        cyc(2'd0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic rd(input string nm, input bit b, input logic [1:0] sel, input logic [31:0] e);
        cyc(sel, 1'b0, 1'b1, 32'h0);
        push(nm, b, 1'b0, e);
    endtask

    task automatic wr(input logic [1:0] sel, input logic [31:0] v);
        cyc(sel, 1'b1, 1'b0, v);
    endtask

    task automatic chk_irq(input string nm, input bit b, input logic e);
        push(nm, b, 1'b1, {31'b0, e});
    endtask

    initial begin
        rstn = 1'b0; irq_a = '0; irq_b = '0;
        reg_sel = '0; reg_write = 1'b0; reg_read = 1'b0; wdata = '0;

        // reset state
        repeat (2) @(posedge clk);
        rd("reset pending", 0, 2'd0, 32'h0); chk_irq("reset irq_out", 0, 1'b0);
        rd("reset enable", 0, 2'd1, 32'h0);
        rd("reset mode", 0, 2'd2, 32'h0);
        rd("reset claim b", 1, 2'd3, 32'h0);
        idle(); rstn = 1'b1;
        repeat (3) idle();

        // masked edge, then enable
        rd("t1 pend n", 0, 2'd0, 32'h0); irq_a = 2'b01;
        rd("t1 pend n+1", 0, 2'd0, 32'h0); irq_a = 2'b00;
        rd("t1 pend n+2", 0, 2'd0, 32'h0);
        rd("t1 pend k+2", 0, 2'd0, 32'h1); chk_irq("t1 irq masked", 0, 1'b0);
        rd("t1 pend hold", 0, 2'd0, 32'h1); chk_irq("t1 irq masked2", 0, 1'b0);
        wr(2'd1, 32'h1); chk_irq("t1 irq at enable write", 0, 1'b0);
        rd("t1 enable", 0, 2'd1, 32'h1); chk_irq("t1 irq edge after", 0, 1'b0);
        rd("t1 pend", 0, 2'd0, 32'h1); chk_irq("t1 irq on", 0, 1'b1);

        // two-line claim sequence
        wr(2'd1, 32'h3);
        wr(2'd0, 32'h3);
        rd("t2 pend cleared", 0, 2'd0, 32'h0); irq_a = 2'b11;
        idle(); irq_a = 2'b00;
        idle();
        idle();
        rd("t2 pend both", 0, 2'd0, 32'h3); chk_irq("t2 irq on", 0, 1'b1);
        rd("t2 claim 1", 0, 2'd3, 32'h1);
        rd("t2 claim 2", 0, 2'd3, 32'h2); chk_irq("t2 irq still", 0, 1'b1);
        rd("t2 claim 0", 0, 2'd3, 32'h0); chk_irq("t2 irq last", 0, 1'b1);
        rd("t2 pend empty", 0, 2'd0, 32'h0); chk_irq("t2 irq off", 0, 1'b0);

        // set beats W1C
        rd("t3 pend 0", 0, 2'd0, 32'h0); irq_a = 2'b01;
        rd("t3 pend q+1", 0, 2'd0, 32'h0); irq_a = 2'b00;
        idle();
        rd("t3 pend set", 0, 2'd0, 32'h1); irq_a = 2'b01;
        idle(); irq_a = 2'b00;
        wr(2'd0, 32'h1);
        rd("t3 set wins", 0, 2'd0, 32'h1);
        wr(2'd0, 32'h1);
        rd("t3 w1c clears", 0, 2'd0, 32'h0);

        // level mode on line 1
        wr(2'd2, 32'h2);
        wr(2'd1, 32'h2);
        rd("t4 pend 0", 0, 2'd0, 32'h0); irq_a = 2'b10;
        idle();
        idle();
        rd("t4 pend level", 0, 2'd0, 32'h2);
        rd("t4 claim 2", 0, 2'd3, 32'h2); chk_irq("t4 irq on", 0, 1'b1);
        wr(2'd0, 32'h2); chk_irq("t4 irq w1c", 0, 1'b1);
        rd("t4 pend after w1c", 0, 2'd0, 32'h2); chk_irq("t4 irq after w1c", 0, 1'b1);
        rd("t4 claim again", 0, 2'd3, 32'h2); chk_irq("t4 irq after claim", 0, 1'b1);
        rd("t4 pend d", 0, 2'd0, 32'h2); chk_irq("t4 irq d", 0, 1'b1); irq_a = 2'b00;
        rd("t4 pend d+1", 0, 2'd0, 32'h2);
        rd("t4 pend d+2", 0, 2'd0, 32'h2); chk_irq("t4 irq d+2", 0, 1'b1);
        rd("t4 pend drop", 0, 2'd0, 32'h0); chk_irq("t4 irq d+3", 0, 1'b1);
        rd("t4 pend d+4", 0, 2'd0, 32'h0); chk_irq("t4 irq drop", 0, 1'b0);

        // async reset mid-pending, then line held high across release
        wr(2'd2, 32'h0);
        wr(2'd1, 32'h1);
        rd("t5 pend 0", 0, 2'd0, 32'h0); irq_a = 2'b01;
        idle(); irq_a = 2'b00;
        idle();
        rd("t5 pend set", 0, 2'd0, 32'h1);
        rd("t5 pend hold", 0, 2'd0, 32'h1); chk_irq("t5 irq on", 0, 1'b1);
        rd("t5 rst pend", 0, 2'd0, 32'h0); rstn = 1'b0; irq_a = 2'b01;
        chk_irq("t5 rst irq", 0, 1'b0);
        rd("t5 rst enable", 0, 2'd1, 32'h0);
        rd("t5 rst mode", 0, 2'd2, 32'h0);
        rd("t5 rel pend r", 0, 2'd0, 32'h0); rstn = 1'b1;
        rd("t5 rel pend r+1", 0, 2'd0, 32'h0);
        rd("t5 rel pend r+2", 0, 2'd0, 32'h0);
        rd("t5 boot edge", 0, 2'd0, 32'h1);
        wr(2'd0, 32'h1);
        rd("t5 cleared", 0, 2'd0, 32'h0);
        repeat (3) idle();
        rd("t5 no re-trigger", 0, 2'd0, 32'h0);

        // 8 lines, 3 sync stages
        irq_a = 2'b00;
        wr(2'd2, 32'h0);
        wr(2'd1, 32'hFF);
        wr(2'd0, 32'hFF);
        rd("t6 claim idle", 1, 2'd3, 32'h0); irq_b = 8'h88;
        rd("t6 pend t+1", 1, 2'd0, 32'h0); irq_b = 8'h00;
        rd("t6 pend t+2", 1, 2'd0, 32'h0);
        rd("t6 pend t+3", 1, 2'd0, 32'h0);
        rd("t6 pend k+3", 1, 2'd0, 32'h88);
        rd("t6 claim 4", 1, 2'd3, 32'h4);
        rd("t6 claim 8", 1, 2'd3, 32'h8); chk_irq("t6 irq on", 1, 1'b1);
        rd("t6 claim 0", 1, 2'd3, 32'h0);
        rd("t6 pend empty", 1, 2'd0, 32'h0); chk_irq("t6 irq off", 1, 1'b0);

        idle();
        @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard drain: got %0d entries left, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
